// File: rtl/counter_cmd_scheduler.sv
// Turns debounced up/down/middle button levels into one-cycle load/add/sub
// command pulses, with hold-to-auto-repeat on up/down and conflict arbitration.
module counter_cmd_scheduler #(
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CNT_W         = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic up,
    input  logic down,
    input  logic middle,
    output logic load,
    output logic add,
    output logic sub,
    output logic repeating
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD_UP,
        S_HOLD_DN,
        S_REP_UP,
        S_REP_DN
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_up_q;
    logic             r_down_q;
    logic             r_middle_q;
    logic             r_load;
    logic             r_add;
    logic             r_sub;
    logic             r_repeating;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             w_load_nxt;
    logic             w_add_nxt;
    logic             w_sub_nxt;
    logic             w_rise_up;
    logic             w_rise_down;
    logic             w_rise_middle;

    assign w_rise_up     = up & ~r_up_q;
    assign w_rise_down   = down & ~r_down_q;
    assign w_rise_middle = middle & ~r_middle_q;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_load_nxt  = 1'b0;
        w_add_nxt   = 1'b0;
        w_sub_nxt   = 1'b0;

        if (w_rise_middle) begin
            w_load_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_timer_nxt = '0;
                    if (w_rise_up && !down) begin
                        w_add_nxt   = 1'b1;
                        w_state_nxt = S_HOLD_UP;
                    end else if (w_rise_down && !up) begin
                        w_sub_nxt   = 1'b1;
                        w_state_nxt = S_HOLD_DN;
                    end
                end
                S_HOLD_UP, S_REP_UP: begin
                    // Pressing the opposite button cancels the hold rather than reversing it.
                    if (!up || down) begin
                        w_state_nxt = S_IDLE;
                        w_timer_nxt = '0;
                    end else if (r_timer == ((r_state == S_HOLD_UP) ? HOLD_LAST : REP_LAST)) begin
                        w_add_nxt   = 1'b1;
                        w_state_nxt = S_REP_UP;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + CNT_W'(1);
                    end
                end
                S_HOLD_DN, S_REP_DN: begin
                    if (!down || up) begin
                        w_state_nxt = S_IDLE;
                        w_timer_nxt = '0;
                    end else if (r_timer == ((r_state == S_HOLD_DN) ? HOLD_LAST : REP_LAST)) begin
                        w_sub_nxt   = 1'b1;
                        w_state_nxt = S_REP_DN;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    // History regs reset high so a button held through reset needs a fresh press.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_up_q      <= 1'b1;
            r_down_q    <= 1'b1;
            r_middle_q  <= 1'b1;
            r_load      <= 1'b0;
            r_add       <= 1'b0;
            r_sub       <= 1'b0;
            r_repeating <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_up_q      <= up;
            r_down_q    <= down;
            r_middle_q  <= middle;
            r_load      <= w_load_nxt;
            r_add       <= w_add_nxt;
            r_sub       <= w_sub_nxt;
            r_repeating <= (w_state_nxt == S_REP_UP) || (w_state_nxt == S_REP_DN);
        end
    end

    assign load      = r_load;
    assign add       = r_add;
    assign sub       = r_sub;
    assign repeating = r_repeating;

endmodule

// File: tb/tb_counter_cmd_scheduler.sv
// Directed bench for counter_cmd_scheduler: expected outputs are queued as each
// input step is driven and popped/compared one cycle later.
module tb_counter_cmd_scheduler;

    localparam int HOLD_CYCLES   = 8;
    localparam int REPEAT_CYCLES = 4;
    localparam int CNT_W         = 4;

    typedef struct packed {
        logic load;
        logic add;
        logic sub;
        logic rep;
    } exp_t;

    logic clk;
    logic reset;
    logic up;
    logic down;
    logic middle;
    logic load;
    logic add;
    logic sub;
    logic repeating;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string tag    = "init";

    counter_cmd_scheduler #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .up       (up),
        .down     (down),
        .middle   (middle),
        .load     (load),
        .add      (add),
        .sub      (sub),
        .repeating(repeating)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge's inputs and queue the outputs expected in the following cycle.
    task automatic step(input int c, input logic u, input logic d, input logic m, input logic r,
                        input logic el, input logic ea, input logic es, input logic er);
        exp_t e;
        @(negedge clk);
        up     = u;
        down   = d;
        middle = m;
        reset  = r;
        sb.push_back('{load: el, add: ea, sub: es, rep: er});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s edge %0d scoreboard empty", tag, c);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (load === e.load) else begin
                errors++;
                $error("FAIL %s edge %0d load observed=%b expected=%b", tag, c, load, e.load);
            end
            checks++;
            assert (add === e.add) else begin
                errors++;
                $error("FAIL %s edge %0d add observed=%b expected=%b", tag, c, add, e.add);
            end
            checks++;
            assert (sub === e.sub) else begin
                errors++;
                $error("FAIL %s edge %0d sub observed=%b expected=%b", tag, c, sub, e.sub);
            end
            checks++;
            assert (repeating === e.rep) else begin
                errors++;
                $error("FAIL %s edge %0d repeating observed=%b expected=%b", tag, c, repeating, e.rep);
            end
        end
    endtask

    task automatic do_reset();
        step(-2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(-1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset  = 1'b1;
        up     = 1'b0;
        down   = 1'b0;
        middle = 1'b0;

        tag = "reset";
        do_reset();

        tag = "short_up";
        for (int c = 0; c < 13; c++)
            step(c, c < 3, 1'b0, 1'b0, 1'b0, 1'b0, c == 0, 1'b0, 1'b0);

        tag = "hold_up";
        for (int c = 0; c < 25; c++)
            step(c, c < 20, 1'b0, 1'b0, 1'b0,
                 1'b0, (c == 0) || (c == 8) || (c == 12) || (c == 16), 1'b0, (c >= 8) && (c <= 19));

        tag = "down_then_mid";
        for (int c = 0; c < 17; c++)
            step(c, 1'b0, c <= 12, c == 12, 1'b0,
                 c == 12, 1'b0, (c == 0) || (c == 8), (c >= 8) && (c <= 11));

        tag = "both_rise";
        for (int c = 0; c < 22; c++)
            step(c, c < 20, c < 20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        tag = "down_then_up";
        for (int c = 0; c < 28; c++)
            step(c, (c >= 2) && (c <= 5), c <= 24, 1'b0, 1'b0, 1'b0, 1'b0, c == 0, 1'b0);

        tag = "up_and_mid";
        do_reset();
        for (int c = 0; c < 12; c++)
            step(c, c <= 9, 1'b0, c == 0, 1'b0, c == 0, 1'b0, 1'b0, 1'b0);

        tag = "reset_mid_rep";
        do_reset();
        for (int c = 0; c < 41; c++)
            step(c, (c <= 29) || ((c >= 35) && (c <= 38)), 1'b0, 1'b0, c == 10,
                 1'b0, (c == 0) || (c == 8) || (c == 35), 1'b0, (c == 8) || (c == 9));

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain leftover observed=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
